pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Sequences the program counter and instruction fetch for the npc core. Owns the PC register,
//  issues one fetch at a time to instruction memory over a valid/ready request plus response
//  strobe, and presents the fetched instruction with its PC to decode. It applies redirects
//  from branch/jump resolution and discards any in-flight fetch made stale by a redirect.
// PARAMETERS
//  CPU_WIDTH  64             PC / address width in bits (matches `CPU_WIDTH)
//  RESET_PC   64'h8000_0000  PC value loaded on reset
// PORTS
//  clk             in   1          rising-edge clock
//  rst_n           in   1          asynchronous active-low reset
//  ena             in   1          run enable; sampled only in IDLE and at HOLD exit
//  redirect_valid  in   1          branch/jump taken; replace PC with redirect_pc
//  redirect_pc     in   CPU_WIDTH  redirect target; must be 4-byte aligned
//  imem_req_valid  out  1          fetch request valid
//  imem_req_addr   out  CPU_WIDTH  fetch address (= PC register)
//  imem_req_ready  in   1          imem accepts request this cycle
//  imem_rsp_valid  in   1          fetch response strobe, one cycle, for oldest accepted request
//  imem_rsp_data   in   32         fetched instruction
//  inst_valid      out  1          instruction available to decode
//  inst_data       out  32         held instruction
//  inst_pc         out  CPU_WIDTH  PC of held instruction
//  inst_ready      in   1          decode consumes instruction
//  misalign_err    out  1          one-cycle pulse: misaligned redirect rejected
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, discard=0, imem_req_valid=0, inst_valid=0,
//   inst_data=0, inst_pc=0, misalign_err=0. All outputs registered except imem_req_addr=pc.
//  States: IDLE, REQ, WAIT, HOLD. imem_req_valid=1 iff REQ; inst_valid=1 iff HOLD.
//  IDLE: ena=1 -> REQ next cycle; else stay.
//  REQ:  valid held until imem_req_ready=1, then -> WAIT. ena ignored (no withdrawal).
//  WAIT: rsp_valid & discard=0 -> inst_data<=rsp_data, inst_pc<=pc, pc<=pc+4, -> HOLD.
//        rsp_valid & discard=1 -> discard<=0, -> REQ (pc already redirected).
//  HOLD: inst_ready=1 -> REQ if ena else IDLE; inst_valid drops next cycle.
//  Redirect (aligned, redirect_pc[1:0]==0), priority over every other event same cycle:
//   - pc<=redirect_pc in all states.
//   - IDLE: stay IDLE. REQ: stay REQ; addr changes next cycle (if req_ready was high the same
//     cycle the old request was accepted -> go WAIT with discard<=1).
//   - WAIT: discard<=1, stay WAIT; if rsp_valid same cycle, drop rsp, discard stays 0, -> REQ.
//   - HOLD: held instruction flushed, inst_ready ignored; -> REQ if ena else IDLE.
//  Misaligned redirect (redirect_pc[1:0]!=0): ignored entirely; misalign_err=1 next cycle only.
//  pc+4 wraps modulo 2^CPU_WIDTH. Exactly one outstanding fetch at any time.
//  Latency: ena high in IDLE -> req_valid next cycle; rsp_valid -> inst_valid next cycle.
//  Reset asserted mid-fetch: state returns to IDLE immediately; stale imem responses arriving
//   while not in WAIT are ignored.
// TESTING
//  1 Reset release, ena=1, imem ready=1, rsp 1 cycle after accept with 32'h00000013 ->
//    req addr 0x80000000, inst_valid with inst_pc=0x80000000; next req addr 0x80000004.
//  2 imem_req_ready low 3 cycles -> req_valid/addr stable 0x80000000 all 3 cycles, WAIT after.
//  3 redirect_valid in WAIT to 0x80000100, rsp arrives 2 cycles later -> rsp dropped,
//    inst_valid stays 0, next req addr 0x80000100.
//  4 HOLD with inst_ready=0 5 cycles, then redirect+inst_ready same cycle to 0x80000200 ->
//    inst_valid 0 next cycle, next req addr 0x80000200, no pc+4 applied to flushed inst.
//  5 redirect_pc=0x80000102 -> misalign_err one-cycle pulse, pc/state unchanged.
//  6 pc=0xFFFF_FFFF_FFFF_FFFC fetch completes -> next req addr 0; rst_n low during WAIT ->
//    IDLE, outputs at reset values, late rsp_valid ignored.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Applies branch/jump redirects and drops responses made stale by them.
module pc_fetch_ctrl #(
  parameter int unsigned           CPU_WIDTH = 64,
  parameter logic [CPU_WIDTH-1:0]  RESET_PC  = CPU_WIDTH'(64'h8000_0000)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  output logic                 imem_req_valid,
  output logic [CPU_WIDTH-1:0] imem_req_addr,
  input  logic                 imem_req_ready,
  input  logic                 imem_rsp_valid,
  input  logic [31:0]          imem_rsp_data,
  output logic                 inst_valid,
  output logic [31:0]          inst_data,
  output logic [CPU_WIDTH-1:0] inst_pc,
  input  logic                 inst_ready,
  output logic                 misalign_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e               state_q, state_d;
  logic [CPU_WIDTH-1:0] pc_q, pc_d;
  logic                 discard_q, discard_d;
  logic [31:0]          inst_data_q, inst_data_d;
  logic [CPU_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                 misalign_q, misalign_d;

  logic redir_ok;
  logic redir_bad;

  // A misaligned target is dropped as if no redirect had been requested.
  assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;
    inst_data_d = inst_data_q;
    inst_pc_d   = inst_pc_q;
    misalign_d  = redir_bad;

    if (redir_ok) begin
      pc_d = redirect_pc;
    end

    unique case (state_q)
      StIdle: begin
        if (!redir_ok && ena) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (imem_req_ready) begin
          state_d = StWait;
          // The request just accepted still targets the old PC.
          if (redir_ok) begin
            discard_d = 1'b1;
          end
        end
      end
      StWait: begin
        if (redir_ok) begin
          if (imem_rsp_valid) begin
            discard_d = 1'b0;
            state_d   = StReq;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = StReq;
          end else begin
            inst_data_d = imem_rsp_data;
            inst_pc_d   = pc_q;
            pc_d        = pc_q + CPU_WIDTH'(4);
            state_d     = StHold;
          end
        end
      end
      StHold: begin
        if (redir_ok || inst_ready) begin
          state_d = ena ? StReq : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      discard_q   <= 1'b0;
      inst_data_q <= '0;
      inst_pc_q   <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      inst_data_q <= inst_data_d;
      inst_pc_q   <= inst_pc_d;
      misalign_q  <= misalign_d;
    end
  end

  assign imem_req_valid = (state_q == StReq);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == StHold);
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; fetched instructions are checked against a scoreboard queue.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        misalign_err;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic iv_prev  = 1'b0;

  pc_fetch_ctrl #(
    .CPU_WIDTH (64),
    .RESET_PC  (64'h8000_0000)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] pc, input logic [31:0] data);
    exp_t e;
    e.pc   = pc;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Each new instruction presented to decode must match the oldest expected fetch.
  always @(negedge clk) begin
    if (rst_n && inst_valid && !iv_prev) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_inst", {32'h0, inst_data}, 64'hffff_ffff_ffff_ffff);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("sb_inst_pc", inst_pc, e.pc);
        check_eq("sb_inst_data", {32'h0, inst_data}, {32'h0, e.data});
      end
    end
    iv_prev = rst_n && inst_valid;
  end

  initial begin
    rst_n          = 1'b0;
    ena            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
    repeat (2) tick();
    check_eq("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    check_eq("rst_req_addr", imem_req_addr, 64'h8000_0000);
    check_eq("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
    check_eq("rst_inst_pc", inst_pc, 64'h0);
    check_eq("rst_misalign", {63'h0, misalign_err}, 64'h0);

    // Basic fetch: request, one-cycle response, hold, consume.
    rst_n          = 1'b1;
    ena            = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    check_eq("t1_req_valid", {63'h0, imem_req_valid}, 64'h1);
    check_eq("t1_req_addr", imem_req_addr, 64'h8000_0000);
    tick();
    check_eq("t1_wait_req_valid", {63'h0, imem_req_valid}, 64'h0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    push_exp(64'h8000_0000, 32'h0000_0013);
    tick();
    imem_rsp_valid = 1'b0;
    check_eq("t1_inst_valid", {63'h0, inst_valid}, 64'h1);
    check_eq("t1_inst_pc", inst_pc, 64'h8000_0000);
    inst_ready = 1'b1;
    tick();
    inst_ready     = 1'b0;
    imem_req_ready = 1'b0;
    check_eq("t1_inst_drop", {63'h0, inst_valid}, 64'h0);
    check_eq("t1_next_addr", imem_req_addr, 64'h8000_0004);

    // Backpressure: request must stay put while not accepted.
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_req_valid", {63'h0, imem_req_valid}, 64'h1);
      check_eq("t2_req_addr", imem_req_addr, 64'h8000_0004);
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    check_eq("t2_wait", {63'h0, imem_req_valid}, 64'h0);

    // Redirect while waiting: the late response is dropped.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    check_eq("t3_still_wait", {63'h0, imem_req_valid}, 64'h0);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hdead_beef;
    tick();
    imem_rsp_valid = 1'b0;
    check_eq("t3_inst_valid", {63'h0, inst_valid}, 64'h0);
    check_eq("t3_req_valid", {63'h0, imem_req_valid}, 64'h1);
    check_eq("t3_req_addr", imem_req_addr, 64'h8000_0100);

    // Hold with no consumer, then flush by redirect.
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0093;
    push_exp(64'h8000_0100, 32'h0010_0093);
    tick();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("t4_hold", {63'h0, inst_valid}, 64'h1);
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    check_eq("t4_flush", {63'h0, inst_valid}, 64'h0);
    check_eq("t4_req_addr", imem_req_addr, 64'h8000_0200);

    // Misaligned redirect is ignored apart from the error pulse.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    check_eq("t5_misalign", {63'h0, misalign_err}, 64'h1);
    check_eq("t5_req_valid", {63'h0, imem_req_valid}, 64'h1);
    check_eq("t5_req_addr", imem_req_addr, 64'h8000_0200);
    tick();
    check_eq("t5_pulse_end", {63'h0, misalign_err}, 64'h0);
    check_eq("t5_addr_kept", imem_req_addr, 64'h8000_0200);

    // Redirect in the same cycle the old request is accepted: its response is discarded.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check_eq("t5b_wait", {63'h0, imem_req_valid}, 64'h0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hbad0_0bad;
    tick();
    imem_rsp_valid = 1'b0;
    check_eq("t5b_refetch", imem_req_addr, 64'h8000_0300);
    check_eq("t5b_no_inst", {63'h0, inst_valid}, 64'h0);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    push_exp(64'h8000_0300, 32'h0000_0013);
    tick();
    imem_rsp_valid = 1'b0;
    ena            = 1'b0;
    inst_ready     = 1'b1;
    tick();
    inst_ready = 1'b0;
    check_eq("t5b_idle_req", {63'h0, imem_req_valid}, 64'h0);
    check_eq("t5b_idle_inst", {63'h0, inst_valid}, 64'h0);

    // PC wrap at the top of the address space, then reset during WAIT.
    ena            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hffff_ffff_ffff_fffc;
    tick();
    redirect_valid = 1'b0;
    check_eq("t6_idle_redirect", {63'h0, imem_req_valid}, 64'h0);
    tick();
    check_eq("t6_req_addr", imem_req_addr, 64'hffff_ffff_ffff_fffc);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0073;
    push_exp(64'hffff_ffff_ffff_fffc, 32'h0000_0073);
    tick();
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b1;
    tick();
    inst_ready = 1'b0;
    check_eq("t6_wrap_addr", imem_req_addr, 64'h0);
    tick();
    check_eq("t6_in_wait", {63'h0, imem_req_valid}, 64'h0);
    rst_n = 1'b0;
    ena   = 1'b0;
    #1;
    check_eq("t6_rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    check_eq("t6_rst_addr", imem_req_addr, 64'h8000_0000);
    check_eq("t6_rst_inst_data", {32'h0, inst_data}, 64'h0);
    check_eq("t6_rst_inst_pc", inst_pc, 64'h0);
    tick();
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    tick();
    imem_rsp_valid = 1'b0;
    check_eq("t6_late_rsp_inst", {63'h0, inst_valid}, 64'h0);
    check_eq("t6_late_rsp_req", {63'h0, imem_req_valid}, 64'h0);
    check_eq("t6_late_rsp_data", {32'h0, inst_data}, 64'h0);
    tick();
    check_eq("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
